// File: rtl/lsu_pkg.sv
// Shared types, funct3 encodings and access-legality check for the load/store unit.
package lsu_pkg;

    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } lsu_state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // True when funct3 is a valid encoding for the access kind and the byte
    // offset is naturally aligned for its size. Unsigned variants are load-only.
    function automatic logic access_ok(input logic       is_store,
                                       input logic [2:0] f3,
                                       input logic [1:0] off);
        logic ok;
        ok = 1'b0;
        case (f3)
            F3_B:    ok = 1'b1;
            F3_H:    ok = !off[0];
            F3_W:    ok = (off == 2'b00);
            F3_BU:   ok = !is_store;
            F3_HU:   ok = !is_store && !off[0];
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/load_align.sv
// Load result formatter: picks the byte/halfword addressed by byte_off out of
// the read word and sign- or zero-extends it according to funct3.
//   rdata     : raw memory word
//   funct3    : load size/sign encoding
//   byte_off  : low address bits of the access
//   load_word : extended result
module load_align
    import lsu_pkg::*;
#(
    parameter int unsigned N = XLEN
) (
    input  logic [N-1:0] rdata,
    input  logic [2:0]   funct3,
    input  logic [1:0]   byte_off,
    output logic [N-1:0] load_word
);

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    // Lane selection
    always_comb begin
        sel_byte = rdata[7:0];
        case (byte_off)
            2'd0: sel_byte = rdata[7:0];
            2'd1: sel_byte = rdata[15:8];
            2'd2: sel_byte = rdata[23:16];
            2'd3: sel_byte = rdata[31:24];
            default: sel_byte = rdata[7:0];
        endcase
        sel_half = byte_off[1] ? rdata[31:16] : rdata[15:0];
    end

    // Extension by access type
    always_comb begin
        load_word = rdata;
        case (funct3)
            F3_B:    load_word = {{(N-8){sel_byte[7]}}, sel_byte};
            F3_BU:   load_word = {{(N-8){1'b0}}, sel_byte};
            F3_H:    load_word = {{(N-16){sel_half[15]}}, sel_half};
            F3_HU:   load_word = {{(N-16){1'b0}}, sel_half};
            default: load_word = rdata;
        endcase
    end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Multi-cycle load/store controller between EX and a valid/ready data memory.
// Latches one legal access, issues it, stalls the core until the response,
// then returns the formatted load word on mem_out.
//   mem_read/mem_write/funct3/addr/store_data : access from EX
//   mem_out    : last completed load result
//   lsu_stall  : hold pipeline (combinational, high from issue cycle until DONE)
//   lsu_fault  : combinational pulse on an illegal access seen in IDLE
//   dmem_*     : request (valid/ready) and response (rsp_valid/rdata) channels
module lsu_mem_ctrl
    import lsu_pkg::*;
#(
    parameter int unsigned N      = XLEN,
    parameter int unsigned STRB_W = N / 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [2:0]        funct3,
    input  logic [N-1:0]      addr,
    input  logic [N-1:0]      store_data,
    output logic [N-1:0]      mem_out,
    output logic              lsu_stall,
    output logic              lsu_fault,
    output logic              dmem_req_valid,
    input  logic              dmem_req_ready,
    output logic              dmem_we,
    output logic [N-1:0]      dmem_addr,
    output logic [N-1:0]      dmem_wdata,
    output logic [STRB_W-1:0] dmem_wstrb,
    input  logic              dmem_rsp_valid,
    input  logic [N-1:0]      dmem_rdata
);

    lsu_state_t        state;
    logic [2:0]        funct3_q;
    logic [1:0]        off_q;
    logic              is_store;
    logic              idle_req;
    logic              legal;
    logic [N-1:0]      load_word;
    logic [N-1:0]      wdata_fmt;
    logic [STRB_W-1:0] wstrb_fmt;

    // A simultaneous read+write is handled as a store
    assign is_store = mem_write;
    assign legal    = access_ok(is_store, funct3, addr[1:0]);
    assign idle_req = (state == IDLE) && (mem_read || mem_write) && !rst;

    assign lsu_stall = (state == REQ) || (state == WAIT) || (idle_req && legal);
    assign lsu_fault = idle_req && !legal;

    // Store lane replication and byte enables
    always_comb begin
        wdata_fmt = store_data;
        wstrb_fmt = '1;
        case (funct3)
            F3_B: begin
                wdata_fmt = N'({4{store_data[7:0]}});
                wstrb_fmt = STRB_W'(4'b0001) << addr[1:0];
            end
            F3_H: begin
                wdata_fmt = N'({2{store_data[15:0]}});
                wstrb_fmt = STRB_W'(4'b0011) << {addr[1], 1'b0};
            end
            default: begin
                wdata_fmt = store_data;
                wstrb_fmt = '1;
            end
        endcase
    end

    load_align #(.N(N)) u_load_align (
        .rdata     (dmem_rdata),
        .funct3    (funct3_q),
        .byte_off  (off_q),
        .load_word (load_word)
    );

    // Access sequencing; request fields are frozen from issue until reset or the next access
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            funct3_q       <= '0;
            off_q          <= '0;
            mem_out        <= '0;
            dmem_req_valid <= 1'b0;
            dmem_we        <= 1'b0;
            dmem_addr      <= '0;
            dmem_wdata     <= '0;
            dmem_wstrb     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if ((mem_read || mem_write) && legal) begin
                        state          <= REQ;
                        dmem_req_valid <= 1'b1;
                        dmem_we        <= is_store;
                        dmem_addr      <= {addr[N-1:2], 2'b00};
                        funct3_q       <= funct3;
                        off_q          <= addr[1:0];
                        dmem_wdata     <= is_store ? wdata_fmt : '0;
                        dmem_wstrb     <= is_store ? wstrb_fmt : '0;
                    end
                end
                REQ: begin
                    if (dmem_req_ready) begin
                        dmem_req_valid <= 1'b0;
                        if (dmem_rsp_valid) begin
                            state <= DONE;
                            if (!dmem_we) begin
                                mem_out <= load_word;
                            end
                        end else begin
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (dmem_rsp_valid) begin
                        state <= DONE;
                        if (!dmem_we) begin
                            mem_out <= load_word;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
